// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared encodings for the store unit
//
// Purpose : size encodings, FSM state encodings and the timeout counter
//           width used by store_unit and store_lane.
// Ports   : none (package).

package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10
  } state_e;

  // Wide enough for the largest TIMEOUT (255).
  localparam int CNT_W = 8;

endpackage

// File: rtl/store_lane.sv
// rtl/store_lane.sv - combinational lane placement and byte-enable generation
//
// Purpose : places store data on the byte lanes selected by size/address,
//           produces little-endian byte enables and flags misalignment.
// Ports   : size      in  2   store size (store_pkg::size_e encoding)
//           addr_lo   in  2   byte offset within the word
//           wdata     in  32  register data
//           lane_data out 32  lane-replicated write data
//           lane_be   out 4   byte enables, bit i = lane i
//           misalign  out 1   half at odd address or word not 4-aligned

module store_lane
  import store_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] lane_data,
  output logic [3:0]  lane_be,
  output logic        misalign
);

  always_comb begin
    lane_data = 32'h0;
    lane_be   = 4'b0000;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        lane_data = {4{wdata[7:0]}};
        lane_be   = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        lane_data = {2{wdata[15:0]}};
        lane_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign  = addr_lo[0];
      end
      SZ_WORD: begin
        lane_data = wdata;
        lane_be   = 4'b1111;
        misalign  = (addr_lo != 2'b00);
      end
      default: begin
        // Reserved size: nothing is driven, the top flags it as an error.
        lane_data = 32'h0;
        lane_be   = 4'b0000;
        misalign  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - single-outstanding store unit between core and memory
//
// Purpose : accepts one core store at a time, issues a lane-placed word
//           write to memory, waits for mem_ack with a TIMEOUT-cycle abort,
//           and reports completion (done) or failure (err) as pulses.
// Config  : define STORE_MISALIGN_TRAP_EN to turn misaligned half/word
//           stores into errors; otherwise low address bits are ignored.
// Ports   : clk       in  1   clock, rising edge
//           rst_n     in  1   asynchronous active-low reset
//           st_valid  in  1   store request, taken when st_valid && st_ready
//           st_ready  out 1   high only in IDLE
//           addr      in  32  byte address
//           wdata     in  32  store data
//           size      in  2   00 byte, 01 half, 10 word, 11 reserved
//           mem_req   out 1   memory write request
//           mem_addr  out 32  word-aligned address
//           mem_wdata out 32  lane-placed data (0 while mem_req low)
//           mem_be    out 4   byte enables (0 while mem_req low)
//           mem_ack   in  1   memory completion, looked at only in REQ
//           done      out 1   one-cycle pulse, store completed
//           err       out 1   one-cycle pulse, reserved/misaligned/timeout

module store_unit
  import store_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        done,
  output logic        err
);

`ifdef STORE_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // Last REQ cycle index before abort; REQ lasts exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic             st_ready_q;
  logic             mem_req_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic [3:0]       mem_be_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0] lane_data;
  logic [3:0]  lane_be;
  logic        misalign;
  logic        acc_err;

  store_lane u_lane (
    .size      (size),
    .addr_lo   (addr[1:0]),
    .wdata     (wdata),
    .lane_data (lane_data),
    .lane_be   (lane_be),
    .misalign  (misalign)
  );

  assign acc_err = (size == SZ_RSVD) || (TRAP_EN && misalign);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      st_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (st_valid) begin
            st_ready_q <= 1'b0;
            if (acc_err) begin
              // Rejected stores skip memory entirely.
              state_q <= S_RESP;
              err_q   <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_wdata_q <= lane_data;
              mem_be_q    <= lane_be;
              cnt_q       <= '0;
            end
          end
        end
        S_REQ: begin
          // Ack wins over a simultaneous timeout expiry.
          if (mem_ack || (cnt_q == CNT_LAST)) begin
            state_q     <= S_RESP;
            mem_req_q   <= 1'b0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'b0000;
            cnt_q       <= '0;
            done_q      <= mem_ack;
            err_q       <= !mem_ack;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          state_q    <= S_IDLE;
          st_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= S_IDLE;
          st_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign st_ready  = st_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed scoreboard bench for store_unit

module tb_store_unit;

  localparam int TO = 15;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        err;

  store_unit #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .addr      (addr),
    .wdata     (wdata),
    .size      (size),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          rejected;  // no mem_req, err one cycle after acceptance
    int          ack_at;    // REQ cycle (1-based) carrying mem_ack, 0 = never
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input bit rej, input int ack_at);
    exp_t e;
    e.addr = a; e.wdata = d; e.be = be; e.rejected = rej; e.ack_at = ack_at;
    sb.push_back(e);
  endtask

  // Drives one store starting at a negedge; compares against the scoreboard head.
  task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz);
    exp_t e;
    int   k;
    e = sb.pop_front();
    check({tag, ".ready"}, 32'(st_ready), 32'd1);
    st_valid = 1'b1; addr = a; wdata = d; size = sz;
    @(negedge clk);
    // Junk on the inputs outside IDLE must be ignored.
    st_valid = 1'b1; addr = $urandom; wdata = $urandom; size = 2'($urandom);
    check({tag, ".busy"}, 32'(st_ready), 32'd0);
    if (e.rejected) begin
      check({tag, ".noreq"}, 32'(mem_req), 32'd0);
      check({tag, ".err"}, 32'(err), 32'd1);
      check({tag, ".nodone"}, 32'(done), 32'd0);
      check({tag, ".be0"}, 32'(mem_be), 32'd0);
    end else begin
      k = 1;
      while (1) begin
        check({tag, ".req"}, 32'(mem_req), 32'd1);
        check({tag, ".addr"}, mem_addr, e.addr);
        check({tag, ".data"}, mem_wdata, e.wdata);
        check({tag, ".be"}, 32'(mem_be), 32'(e.be));
        mem_ack = (k == e.ack_at);
        @(negedge clk);
        mem_ack = 1'b0;
        if (!mem_req) break;
        k++;
        if (k > 3 * TO) begin
          check({tag, ".req_stuck"}, 32'(mem_req), 32'd0);
          break;
        end
      end
      check({tag, ".reqcycles"}, 32'(k), (e.ack_at > 0) ? 32'(e.ack_at) : 32'(TO));
      check({tag, ".done"}, 32'(done), (e.ack_at > 0) ? 32'd1 : 32'd0);
      check({tag, ".err"}, 32'(err), (e.ack_at > 0) ? 32'd0 : 32'd1);
      check({tag, ".idle_be"}, 32'(mem_be), 32'd0);
      check({tag, ".idle_data"}, mem_wdata, 32'd0);
    end
    st_valid = 1'b0;
    @(negedge clk);
    check({tag, ".pulse_end"}, 32'({done, err}), 32'd0);
    check({tag, ".ready_back"}, 32'(st_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; addr = '0; wdata = '0; size = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.ready", 32'(st_ready), 32'd1);
    check("rst.req", 32'(mem_req), 32'd0);
    check("rst.addr", mem_addr, 32'd0);
    check("rst.data", mem_wdata, 32'd0);
    check("rst.be", 32'(mem_be), 32'd0);
    check("rst.pulses", 32'({done, err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    push(32'h0000_1000, 32'hDDDD_DDDD, 4'b1000, 1'b0, 3);
    store("sb_1003", 32'h0000_1003, 32'hAABB_CCDD, 2'b00);

    push(32'h0000_2000, 32'h5678_5678, 4'b1100, 1'b0, 1);
    store("sh_2002", 32'h0000_2002, 32'h1234_5678, 2'b01);

    push(32'h0000_1000, 32'hEEEE_EEEE, 4'b0010, 1'b0, 1);
    store("sb_1001", 32'h0000_1001, 32'h0000_00EE, 2'b00);

    push(32'h0000_2000, 32'h1234_1234, 4'b0011, 1'b0, 2);
    store("sh_2000", 32'h0000_2000, 32'hFFFF_1234, 2'b01);

    push(32'h0000_3000, 32'hCAFE_F00D, 4'b1111, 1'b0, 0);
    store("sw_timeout", 32'h0000_3000, 32'hCAFE_F00D, 2'b10);

    // Ack on the very cycle the timeout would expire counts as success.
    push(32'h0000_3000, 32'h1111_2222, 4'b1111, 1'b0, TO);
    store("sw_ack_last", 32'h0000_3000, 32'h1111_2222, 2'b10);

`ifdef STORE_MISALIGN_TRAP_EN
    push(32'h0, 32'h0, 4'b0000, 1'b1, 0);
    store("sw_3001", 32'h0000_3001, 32'h0102_0304, 2'b10);
    push(32'h0, 32'h0, 4'b0000, 1'b1, 0);
    store("sh_2001", 32'h0000_2001, 32'h0000_ABCD, 2'b01);
`else
    push(32'h0000_3000, 32'h0102_0304, 4'b1111, 1'b0, 2);
    store("sw_3001", 32'h0000_3001, 32'h0102_0304, 2'b10);
    push(32'h0000_2000, 32'hABCD_ABCD, 4'b0011, 1'b0, 1);
    store("sh_2001", 32'h0000_2001, 32'h0000_ABCD, 2'b01);
`endif

    push(32'h0, 32'h0, 4'b0000, 1'b1, 0);
    store("rsvd", 32'h0000_5000, 32'h5555_AAAA, 2'b11);

    // Reset in the middle of REQ: outputs clear immediately, no pulses follow.
    st_valid = 1'b1; addr = 32'h0000_4000; wdata = 32'h8765_4321; size = 2'b10;
    @(negedge clk);
    st_valid = 1'b0;
    check("mid.req", 32'(mem_req), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid.rst_req", 32'(mem_req), 32'd0);
    check("mid.rst_ready", 32'(st_ready), 32'd1);
    check("mid.rst_addr", mem_addr, 32'd0);
    check("mid.rst_data", mem_wdata, 32'd0);
    check("mid.rst_be", 32'(mem_be), 32'd0);
    check("mid.rst_pulses", 32'({done, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mid.after_pulses", 32'({done, err}), 32'd0);
    end

    push(32'h0000_6000, 32'h7777_7777, 4'b0100, 1'b0, 2);
    store("sb_after_rst", 32'h0000_6002, 32'h0000_0077, 2'b00);

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
